// File: rtl/cdb_arb2.sv
// cdb_arb2: two-requester arbiter driving a one-entry common data bus register.
// Requester 0 is the ALU, requester 1 is the LSU. Data is steered through a
// mux2x64 instance addressed by mux_sel; the tag follows the same select.
// Build option: define CDB_ARB_RR_EN for round-robin arbitration; without it
// requester 0 always has priority on contention.

// mux2x64: bit-sliced 2:1 mux, bit i of input j lives at muxIns[i][j].
module mux2x64 (
    input  logic [63:0][1:0] muxIns,
    input  logic             addr,
    output logic [63:0]      muxOut
);

    // Pick bit addr out of every 2-bit slice.
    always_comb begin
        muxOut = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            muxOut[i] = muxIns[i][addr];
        end
    end

endmodule

module cdb_arb2 (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [63:0][1:0] req_data,
    input  logic [5:0]       req_tag0,
    input  logic [5:0]       req_tag1,
    output logic [1:0]       req_ready,
    output logic             mux_sel,
    output logic             cdb_valid,
    output logic [63:0]      cdb_data,
    output logic [5:0]       cdb_tag,
    input  logic             cdb_ready
);

    logic        prio;
    logic        winner;
    logic        load_en;
    logic        transfer;
    logic [63:0] sel_data;
    logic [5:0]  sel_tag;

    assign load_en = !cdb_valid || cdb_ready;

    // Grant: a lone requester wins outright, otherwise the priority pointer decides.
    always_comb begin
        winner = prio;
        case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = prio;
        endcase
    end

    assign mux_sel = winner;

    // Handshake back to the winner only when the bus register can take a result.
    always_comb begin
        req_ready = '0;
        if (!reset && load_en && req_valid[winner]) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    mux2x64 u_mux (
        .muxIns (req_data),
        .addr   (mux_sel),
        .muxOut (sel_data)
    );

    assign sel_tag = mux_sel ? req_tag1 : req_tag0;

    // Bus register: load on transfer, drain when consumed, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
        end else if (transfer) begin
            cdb_valid <= 1'b1;
            cdb_data  <= sel_data;
            cdb_tag   <= sel_tag;
        end else if (cdb_ready) begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_RR_EN
    // Round-robin pointer: after each transfer the loser gets priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (transfer) begin
            prio <= ~winner;
        end
    end
`else
    // Fixed priority: requester 0 always wins contention.
    assign prio = 1'b0;
`endif

endmodule
